dma: RTL and testbench

Bus-master DMA engine between the JTAG-side ping-pong buffer and the Gecko5 system bus. When a buffer half is ready it reads a two-word descriptor from that half, arbitrates for the bus, and performs one burst. A write burst sends buffer words to memory; a read burst stores memory words into the inbound buffer. It then pulses `switch` to swap buffer halves.

---
 rtl/dma_pkg.sv | 37 +++
 rtl/dma_descriptor.sv | 80 ++++++++
 rtl/dma.sv | 209 ++++++++++++++++++++
 tb/tb_dma.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA engine.
// Optional feature macro: DMA_READ_EN (enables read bursts into the inbound buffer).
package dma_pkg;

   typedef enum logic [3:0] {
      StIdle,
      StFetchA,
      StFetchC,
      StLatch,
      StRequest,
      StBegin,
      StWdata,
`ifdef DMA_READ_EN
      StRdata,
`endif
      StWend,
      StDone
   } dma_state_e;

   // Descriptor word indices inside a buffer half
   localparam int unsigned DescAddrIdx = 0;
   localparam int unsigned DescCtrlIdx = 1;
   localparam int unsigned DescDataIdx = 2;

   // Control word fields
   localparam int unsigned CtrlRnwBit  = 31;
   localparam int unsigned CtrlSizeMsb = 7;
   localparam int unsigned CtrlSizeLsb = 0;

   localparam logic [3:0] ByteEnAll = 4'hF;

   // Burst length minus one, taken from the control word
   function automatic logic [7:0] ctrl_size(input logic [31:0] ctrl);
      return ctrl[CtrlSizeMsb:CtrlSizeLsb];
   endfunction

endpackage

// File: rtl/dma_descriptor.sv
// Descriptor holding registers (bus address, burst size, direction) and the beat counter.
// Optional feature macro: DMA_READ_EN (adds the direction bit).
module dma_descriptor
   import dma_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        latch_addr_i,
   input  logic        latch_ctrl_i,
   input  logic        beat_clr_i,
   input  logic        beat_inc_i,
   input  logic [31:0] pop_data_i,
`ifdef DMA_READ_EN
   output logic        rnw_o,
`endif
   output logic [31:0] addr_o,
   output logic [7:0]  size_o,
   output logic [7:0]  beat_o,
   output logic        last_beat_o
);

   logic [31:0] addr_q, addr_d;
   logic [7:0]  size_q, size_d;
   logic [7:0]  beat_q, beat_d;
`ifdef DMA_READ_EN
   logic        rnw_q, rnw_d;
`endif

   // Next-state for descriptor fields and the beat counter
   always_comb begin
      addr_d = addr_q;
      size_d = size_q;
      beat_d = beat_q;
`ifdef DMA_READ_EN
      rnw_d  = rnw_q;
`endif
      if (latch_addr_i) begin
         addr_d = pop_data_i;
      end
      if (latch_ctrl_i) begin
         size_d = ctrl_size(pop_data_i);
`ifdef DMA_READ_EN
         rnw_d  = pop_data_i[CtrlRnwBit];
`endif
      end
      if (beat_clr_i) begin
         beat_d = 8'd0;
      end else if (beat_inc_i) begin
         beat_d = beat_q + 8'd1;
      end
   end

   // Descriptor registers with synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         addr_q <= 32'd0;
         size_q <= 8'd0;
         beat_q <= 8'd0;
`ifdef DMA_READ_EN
         rnw_q  <= 1'b0;
`endif
      end else begin
         addr_q <= addr_d;
         size_q <= size_d;
         beat_q <= beat_d;
`ifdef DMA_READ_EN
         rnw_q  <= rnw_d;
`endif
      end
   end

   assign addr_o      = addr_q;
   assign size_o      = size_q;
   assign beat_o      = beat_q;
   assign last_beat_o = (beat_q == size_q);
`ifdef DMA_READ_EN
   assign rnw_o       = rnw_q;
`endif

endmodule

// File: rtl/dma.sv
// Bus-master DMA engine between the JTAG ping-pong buffer and the Gecko5 bus.
// Optional feature macro: DMA_READ_EN (read bursts; otherwise every burst is a write).
module dma
   import dma_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        dataReady,
   output logic [31:0] popAddress,
   input  logic [31:0] popData,
   output logic        push,
   output logic [31:0] pushAddress,
   output logic [31:0] pushData,
   output logic        switch,
   output logic        request,
   input  logic        granted,
   input  logic [31:0] address_dataIN,
   input  logic        end_transactionIN,
   input  logic        data_validIN,
   input  logic        busyIN,
   input  logic        errorIN,
   output logic [31:0] address_dataOUT,
   output logic [3:0]  byte_enableOUT,
   output logic [7:0]  busrt_sizeOUT,
   output logic        read_n_writeOUT,
   output logic        begin_transactionOUT,
   output logic        end_transactionOUT,
   output logic        data_validOUT,
   output logic        busyOUT
);

   dma_state_e  state_q, state_d;
   logic        wphase_q, wphase_d;  // 0: fetch cycle, 1: present cycle of a write beat

   logic        latch_addr, latch_ctrl, beat_clr, beat_inc;
   logic [31:0] desc_addr;
   logic [7:0]  desc_size;
   logic [7:0]  beat;
   logic        last_beat;
   logic        is_read;

`ifdef DMA_READ_EN
   logic        desc_rnw;
   logic        rd_valid_q, rd_valid_d;
   logic [31:0] rd_data_q, rd_data_d;
   logic        rd_end_q, rd_end_d;
   assign is_read = desc_rnw;
`else
   logic        unused_rd;
   assign is_read   = 1'b0;
   assign unused_rd = ^{data_validIN, address_dataIN, end_transactionIN};
`endif

   dma_descriptor u_descriptor (
      .clock        (clock),
      .reset        (reset),
      .latch_addr_i (latch_addr),
      .latch_ctrl_i (latch_ctrl),
      .beat_clr_i   (beat_clr),
      .beat_inc_i   (beat_inc),
      .pop_data_i   (popData),
`ifdef DMA_READ_EN
      .rnw_o        (desc_rnw),
`endif
      .addr_o       (desc_addr),
      .size_o       (desc_size),
      .beat_o       (beat),
      .last_beat_o  (last_beat)
   );

   assign busyOUT = 1'b0;

   // Next-state and all outputs; every output idles at 0
   always_comb begin
      state_d              = state_q;
      wphase_d             = wphase_q;
      latch_addr           = 1'b0;
      latch_ctrl           = 1'b0;
      beat_clr             = 1'b0;
      beat_inc             = 1'b0;
      popAddress           = 32'd0;
      push                 = 1'b0;
      pushAddress          = 32'd0;
      pushData             = 32'd0;
      switch               = 1'b0;
      request              = 1'b0;
      address_dataOUT      = 32'd0;
      byte_enableOUT       = 4'd0;
      busrt_sizeOUT        = 8'd0;
      read_n_writeOUT      = 1'b0;
      begin_transactionOUT = 1'b0;
      end_transactionOUT   = 1'b0;
      data_validOUT        = 1'b0;
`ifdef DMA_READ_EN
      // Beats arriving after the slave ended (or errored) are dropped
      rd_valid_d = (state_q == StRdata) && data_validIN && !rd_end_q && !errorIN;
      rd_data_d  = data_validIN ? address_dataIN : rd_data_q;
      rd_end_d   = (state_q == StRdata) && (rd_end_q || end_transactionIN);
`endif

      case (state_q)
         StIdle: begin
            popAddress = 32'(DescAddrIdx);
            if (dataReady) state_d = StFetchA;
         end
         StFetchA: begin
            popAddress = 32'(DescAddrIdx);
            state_d    = StFetchC;
         end
         StFetchC: begin
            // popData now carries word 0 addressed during FETCH_A
            popAddress = 32'(DescCtrlIdx);
            latch_addr = 1'b1;
            state_d    = StLatch;
         end
         StLatch: begin
            latch_ctrl = 1'b1;
            beat_clr   = 1'b1;
            state_d    = StRequest;
         end
         StRequest: begin
            request = 1'b1;
            if (granted) state_d = StBegin;
         end
         StBegin: begin
            begin_transactionOUT = 1'b1;
            address_dataOUT      = desc_addr;
            byte_enableOUT       = ByteEnAll;
            busrt_sizeOUT        = desc_size;
            read_n_writeOUT      = is_read;
            wphase_d             = 1'b0;
            if (errorIN) begin
               state_d = StWend;
            end else if (is_read) begin
`ifdef DMA_READ_EN
               state_d = StRdata;
`endif
            end else begin
               state_d = StWdata;
            end
         end
         StWdata: begin
            // Address held through the present cycle so the RAM keeps returning the beat
            popAddress = 32'(DescDataIdx) + {24'd0, beat};
            if (wphase_q) begin
               data_validOUT   = 1'b1;
               address_dataOUT = popData;
               if (errorIN) begin
                  state_d = StWend;
               end else if (!busyIN) begin
                  if (last_beat) begin
                     state_d = StWend;
                  end else begin
                     beat_inc = 1'b1;
                     wphase_d = 1'b0;
                  end
               end
            end else begin
               if (errorIN) state_d = StWend;
               else         wphase_d = 1'b1;
            end
         end
`ifdef DMA_READ_EN
         StRdata: begin
            push        = rd_valid_q;
            pushAddress = {24'd0, beat};
            pushData    = rd_data_q;
            beat_inc    = rd_valid_q;
            if (errorIN) begin
               state_d = StDone;
            end else if ((end_transactionIN || rd_end_q) && !rd_valid_d) begin
               state_d = StDone;
            end
         end
`endif
         StWend: begin
            end_transactionOUT = 1'b1;
            state_d            = StDone;
         end
         StDone: begin
            switch  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= StIdle;
         wphase_q   <= 1'b0;
`ifdef DMA_READ_EN
         rd_valid_q <= 1'b0;
         rd_data_q  <= 32'd0;
         rd_end_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         wphase_q   <= wphase_d;
`ifdef DMA_READ_EN
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         rd_end_q   <= rd_end_d;
`endif
      end
   end

endmodule

// File: tb/tb_dma.sv
// Self-checking bench for dma: table of write descriptors plus hand-written corner sequences.
module tb_dma;

`ifdef DMA_READ_EN
   localparam bit ReadEn = 1'b1;
`else
   localparam bit ReadEn = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset;
   logic        dataReady;
   logic [31:0] popAddress;
   logic [31:0] popData;
   logic        push;
   logic [31:0] pushAddress;
   logic [31:0] pushData;
   logic        switch;
   logic        request;
   logic        granted;
   logic [31:0] address_dataIN;
   logic        end_transactionIN;
   logic        data_validIN;
   logic        busyIN;
   logic        errorIN;
   logic [31:0] address_dataOUT;
   logic [3:0]  byte_enableOUT;
   logic [7:0]  busrt_sizeOUT;
   logic        read_n_writeOUT;
   logic        begin_transactionOUT;
   logic        end_transactionOUT;
   logic        data_validOUT;
   logic        busyOUT;

   dma dut (
      .clock                (clock),
      .reset                (reset),
      .dataReady            (dataReady),
      .popAddress           (popAddress),
      .popData              (popData),
      .push                 (push),
      .pushAddress          (pushAddress),
      .pushData             (pushData),
      .switch               (switch),
      .request              (request),
      .granted              (granted),
      .address_dataIN       (address_dataIN),
      .end_transactionIN    (end_transactionIN),
      .data_validIN         (data_validIN),
      .busyIN               (busyIN),
      .errorIN              (errorIN),
      .address_dataOUT      (address_dataOUT),
      .byte_enableOUT       (byte_enableOUT),
      .busrt_sizeOUT        (busrt_sizeOUT),
      .read_n_writeOUT      (read_n_writeOUT),
      .begin_transactionOUT (begin_transactionOUT),
      .end_transactionOUT   (end_transactionOUT),
      .data_validOUT        (data_validOUT),
      .busyOUT              (busyOUT)
   );

   always #5 clock = ~clock;

   // Outbound buffer half: synchronous-read RAM
   logic [31:0] obuf [16];
   always @(posedge clock) popData <= obuf[popAddress[3:0]];

   typedef struct {
      logic [31:0] addr;
      logic [31:0] ctrl;
      logic [31:0] payload [4];
      int          stall_beat;
      int          stall_len;
      int          err_beat;
      int          grant_delay;
      int          exp_beats;
   } vec_t;

`ifdef DMA_READ_EN
   localparam int NumVec = 4;
`else
   localparam int NumVec = 5;
`endif
   vec_t vecs [NumVec];

   logic [31:0] wq [$];   // expected write beats
   logic [31:0] rq [$];   // expected inbound pushes
   int checks = 0;
   int errors = 0;
   int n_begin, n_end, n_switch, n_beats, n_push, n_dv;
   int cyc, begin_cyc, end_cyc, grant_cyc;
   int stall_left, stall_beat, err_beat;
   logic [31:0] exp_addr;
   logic [7:0]  exp_size;
   logic        exp_rnw;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic clear_counts();
      n_begin = 0; n_end = 0; n_switch = 0; n_beats = 0; n_push = 0; n_dv = 0;
      cyc = 0; begin_cyc = -1; end_cyc = -1; grant_cyc = -1;
      stall_left = 0; stall_beat = 255; err_beat = 255;
      wq.delete();
      rq.delete();
   endtask

   task automatic check_outputs_zero(input string name);
      check({name, " outs"}, {31'd0, |{push, pushAddress, pushData, switch, request,
            address_dataOUT, byte_enableOUT, busrt_sizeOUT, read_n_writeOUT,
            begin_transactionOUT, end_transactionOUT, data_validOUT, busyOUT}}, 32'd0);
      check({name, " popAddress"}, popAddress, 32'd0);
   endtask

   // Called at every falling edge: observe outputs, act as bus slave for the next edge
   task automatic sample();
      cyc++;
      if (begin_transactionOUT) begin
         n_begin++;
         begin_cyc = cyc;
         check("begin addr", address_dataOUT, exp_addr);
         check("begin byte_en", {28'd0, byte_enableOUT}, 32'hF);
         check("begin size", {24'd0, busrt_sizeOUT}, {24'd0, exp_size});
         check("begin rnw", {31'd0, read_n_writeOUT}, {31'd0, exp_rnw});
      end
      if (end_transactionOUT) begin
         n_end++;
         end_cyc = cyc;
      end
      if (switch) n_switch++;
      errorIN = 1'b0;
      busyIN  = 1'b0;
      if (data_validOUT) begin
         n_dv++;
         if (n_beats == err_beat) begin
            errorIN = 1'b1;
            busyIN  = 1'b1;
         end else if (wq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra beat: got %h required no beat", address_dataOUT);
         end else if (n_beats == stall_beat && stall_left > 0) begin
            busyIN = 1'b1;
            stall_left--;
            check("stall hold", address_dataOUT, wq[0]);
         end else begin
            n_beats++;
            check("write beat", address_dataOUT, wq.pop_front());
         end
      end
      if (push) begin
         check("push index", pushAddress, n_push);
         if (rq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra push: got %h required no push", pushData);
         end else begin
            check("push data", pushData, rq.pop_front());
         end
         n_push++;
      end
   endtask

   // Raise dataReady and wait for request; returns cycles observed
   task automatic wait_request(output int lat);
      lat = 0;
      dataReady = 1'b1;
      while (!request && lat < 20) begin
         @(negedge clock);
         sample();
         lat++;
      end
      check("request seen", {31'd0, request}, 32'd1);
      // dataReady is sampled in IDLE, then FETCH_A, FETCH_C, LATCH precede REQUEST
      check("request latency >= 3", {31'd0, lat >= 3}, 32'd1);
   endtask

   task automatic wait_switch();
      int guard;
      guard = 0;
      while (n_switch == 0 && guard < 300) begin
         @(negedge clock);
         sample();
         guard++;
      end
      check("switch before timeout", {31'd0, n_switch != 0}, 32'd1);
      dataReady = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      int lat;
      clear_counts();
      obuf[0] = v.addr;
      obuf[1] = v.ctrl;
      for (int i = 0; i < 4; i++) obuf[2 + i] = v.payload[i];
      for (int i = 0; i < v.exp_beats + (v.err_beat < 255 ? 1 : 0); i++) begin
         wq.push_back(v.payload[i]);
      end
      exp_addr   = v.addr;
      exp_size   = v.ctrl[7:0];
      exp_rnw    = ReadEn & v.ctrl[31];
      stall_beat = v.stall_beat;
      stall_left = v.stall_len;
      err_beat   = v.err_beat;
      wait_request(lat);
      for (int i = 0; i < v.grant_delay; i++) begin
         @(negedge clock);
         sample();
         check("request held", {31'd0, request}, 32'd1);
      end
      granted   = 1'b1;
      grant_cyc = cyc;
      @(negedge clock);
      granted = 1'b0;
      sample();
      wait_switch();
      check("grant->begin", begin_cyc - grant_cyc, 32'd1);
      check("begin count", n_begin, 32'd1);
      check("end count", n_end, 32'd1);
      check("switch count", n_switch, 32'd1);
      check("beats", n_beats, v.exp_beats);
      if (v.err_beat == 255) begin
         check("burst cycles", end_cyc - begin_cyc, 2 * v.exp_beats + 1 + v.stall_len);
      end
      @(negedge clock);
      sample();
      check("switch one-shot", {31'd0, switch}, 32'd0);
      check("back to idle", {31'd0, request}, 32'd0);
   endtask

   function automatic vec_t mk(input logic [31:0] a, input logic [31:0] c,
                               input logic [31:0] p0, input logic [31:0] p1,
                               input logic [31:0] p2, input logic [31:0] p3,
                               input int sb, input int sl, input int eb, input int gd,
                               input int nb);
      vec_t v;
      v.addr = a; v.ctrl = c;
      v.payload[0] = p0; v.payload[1] = p1; v.payload[2] = p2; v.payload[3] = p3;
      v.stall_beat = sb; v.stall_len = sl; v.err_beat = eb; v.grant_delay = gd;
      v.exp_beats = nb;
      return v;
   endfunction

   initial begin
      int lat;
      int guard;
      logic [31:0] rvals [3];

      vecs[0] = mk(32'h1000, 32'h1, 32'hA5A5A5A5, 32'h5A5A5A5A, 0, 0, 255, 0, 255, 0, 2);
      vecs[1] = mk(32'h2000, 32'h1, 32'h11111111, 32'h22222222, 0, 0, 0, 5, 255, 2, 2);
      vecs[2] = mk(32'h3000, 32'h3, 32'hC0, 32'hC1, 32'hC2, 32'hC3, 255, 0, 1, 1, 1);
      vecs[3] = mk(32'h4000, 32'h0, 32'hDEADBEEF, 0, 0, 0, 255, 0, 255, 3, 1);
`ifndef DMA_READ_EN
      // Direction bit must be ignored: plain 4-beat write
      vecs[4] = mk(32'h5000, 32'h8000_0003, 32'h1, 32'h2, 32'h3, 32'h4, 255, 0, 255, 0, 4);
`endif
      for (int i = 0; i < 16; i++) obuf[i] = 32'd0;

      reset = 1'b1; dataReady = 1'b0; granted = 1'b0; address_dataIN = 32'd0;
      end_transactionIN = 1'b0; data_validIN = 1'b0; busyIN = 1'b0; errorIN = 1'b0;
      clear_counts();
      repeat (3) @(negedge clock);
      check_outputs_zero("reset");
      reset = 1'b0;

      // Grant outside REQUEST must not start anything
      granted = 1'b1;
      @(negedge clock);
      granted = 1'b0;
      repeat (4) begin
         @(negedge clock);
         sample();
      end
      check("stray grant begin", n_begin, 32'd0);
      check_outputs_zero("stray grant");

      for (int i = 0; i < NumVec; i++) run_vec(vecs[i]);

      // No grant: request held, no bus activity; then reset mid-REQUEST
      clear_counts();
      obuf[0] = 32'h6000;
      obuf[1] = 32'h1;
      wait_request(lat);
      repeat (40) begin
         @(negedge clock);
         sample();
      end
      check("no-grant request held", {31'd0, request}, 32'd1);
      check("no-grant begin", n_begin, 32'd0);
      check("no-grant beats", n_dv, 32'd0);
      reset = 1'b1;
      @(negedge clock);
      sample();
      check_outputs_zero("reset mid-request");
      reset = 1'b0;
      dataReady = 1'b0;
      repeat (4) begin
         @(negedge clock);
         sample();
      end
      check("reset abort end", n_end, 32'd0);
      check("reset abort switch", n_switch, 32'd0);
      check("idle after reset", {31'd0, request}, 32'd0);

`ifdef DMA_READ_EN
      // Read burst of three beats into the inbound buffer
      clear_counts();
      obuf[0]  = 32'h7000;
      obuf[1]  = 32'h8000_0002;
      exp_addr = 32'h7000;
      exp_size = 8'd2;
      exp_rnw  = 1'b1;
      rvals[0] = 32'h11; rvals[1] = 32'h22; rvals[2] = 32'h33;
      wait_request(lat);
      granted = 1'b1;
      @(negedge clock);
      granted = 1'b0;
      sample();
      check("read begin", n_begin, 32'd1);
      @(negedge clock);
      sample();
      for (int i = 0; i < 3; i++) begin
         data_validIN   = 1'b1;
         address_dataIN = rvals[i];
         rq.push_back(rvals[i]);
         @(negedge clock);
         sample();
      end
      data_validIN      = 1'b0;
      end_transactionIN = 1'b1;
      @(negedge clock);
      end_transactionIN = 1'b0;
      sample();
      wait_switch();
      check("read pushes", n_push, 32'd3);
      check("read switch", n_switch, 32'd1);
      check("read no end_out", n_end, 32'd0);
      check("read no write beats", n_dv, 32'd0);
`else
      guard = 0;
      rvals[0] = 32'd0;
      check("read path idle", {31'd0, push | read_n_writeOUT}, {31'd0, rvals[0][0]});
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

endmodule
